// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory load/store sequencer.
//   state_e    : sequencer FSM states (IDLE, ACCESS, RESP)
//   BEAT_W     : width of the byte-beat counter
//   WORD_BEATS : byte beats in a word access
//   BYTE_W     : width of one memory cell
//   last_beat(): final beat index for a byte or word request
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int BEAT_W     = 2;
  localparam int WORD_BEATS = 4;
  localparam int BYTE_W     = 8;

  // Byte requests finish on beat 0, word requests on beat 3.
  function automatic logic [BEAT_W-1:0] last_beat(input logic word);
    logic [BEAT_W-1:0] lb;
    if (word) begin
      lb = 2'd3;
    end else begin
      lb = 2'd0;
    end
    return lb;
  endfunction

endpackage

// File: rtl/dmem_byte_pack.sv
// -----------------------------------------------------------------------------
// dmem_byte_pack
// Byte-lane accumulator that assembles little-endian read data one byte per
// beat.
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset (accumulator -> 0)
//   clr_i   in   clear the whole accumulator (has priority over ld_i)
//   ld_i    in   write byte_i into lane lane_i
//   lane_i  in   byte lane index (0 = bits 7:0)
//   byte_i  in   byte to store in the selected lane
//   data_o  out  assembled 32-bit word
// -----------------------------------------------------------------------------
module dmem_byte_pack
  import dmem_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic                         ld_i,
  input  logic [BEAT_W-1:0]            lane_i,
  input  logic [BYTE_W-1:0]            byte_i,
  output logic [WORD_BEATS*BYTE_W-1:0] data_o
);

  logic [WORD_BEATS*BYTE_W-1:0] acc_q;
  logic [WORD_BEATS*BYTE_W-1:0] acc_d;

  // Next accumulator value: clear, single-lane load, or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = 32'h0000_0000;
    end else if (ld_i) begin
      acc_d[{lane_i, 3'b000} +: BYTE_W] = byte_i;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= 32'h0000_0000;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign data_o = acc_q;

endmodule

// File: rtl/dmem_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_seq_ctrl
// Multi-cycle load/store sequencer between the MEM stage and a byte-wide
// little-endian data memory. A byte request takes one memory beat, a word
// request four; read bytes are assembled and returned with a one-cycle
// response pulse while stall freezes the pipeline.
//
// Ports:
//   clk, reset              clock (rising edge), async active-high reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_word     1=store/0=load, 1=word/0=byte
//   req_addr, req_wdata     byte address, store data
//   resp_valid              one-cycle completion pulse
//   resp_rdata, resp_err    load data, out-of-range (or misaligned) flag
//   stall                   req_valid & ~resp_valid
//   mem_addr/re/we/wdata    byte memory interface
//   mem_rdata               combinational read byte for mem_addr
//
// Build option: DMEM_ALIGN_CHK_EN -- when defined, a word request whose
// address is not 4-byte aligned goes straight to RESP with resp_err=1 and
// performs no memory access.
// -----------------------------------------------------------------------------
module dmem_seq_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_word,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [31:0] MEM_DEPTH_C = 32'(MEM_DEPTH);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic              word_q, word_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic              acc_clr_s;
  logic              acc_ld_s;
  logic [7:0]        acc_byte_s;
  logic [31:0]       acc_data_s;
  logic [32:0]       beat_sum_s;
  logic              in_range_s;
  logic              in_access_s;

  // Beat address in 33 bits so a wrap past 0xFFFFFFFF shows up as a carry
  // and is treated as out of range instead of aliasing onto low addresses.
  assign beat_sum_s  = {1'b0, addr_q} + {31'b0, beat_q};
  assign in_range_s  = ~beat_sum_s[32] && (beat_sum_s[31:0] < MEM_DEPTH_C);
  assign in_access_s = (state_q == ACCESS);

  dmem_byte_pack u_pack (
    .clk    (clk),
    .rst    (reset),
    .clr_i  (acc_clr_s),
    .ld_i   (acc_ld_s),
    .lane_i (beat_q),
    .byte_i (acc_byte_s),
    .data_o (acc_data_s)
  );

  // Next-state logic: handshake capture, beat sequencing, error tracking.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    beat_d     = beat_q;
    err_d      = err_q;
    acc_clr_s  = 1'b0;
    acc_ld_s   = 1'b0;
    acc_byte_s = 8'h00;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d   = req_write;
          word_d    = req_word;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          beat_d    = 2'd0;
          err_d     = 1'b0;
          acc_clr_s = 1'b1;
`ifdef DMEM_ALIGN_CHK_EN
          if (req_word && (req_addr[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ACCESS;
          end
`else
          state_d = ACCESS;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Loads fill the current lane; an out-of-range beat loads zero.
        if (!write_q) begin
          acc_ld_s = 1'b1;
          if (in_range_s) begin
            acc_byte_s = mem_rdata;
          end else begin
            acc_byte_s = 8'h00;
          end
        end else begin
          acc_ld_s = 1'b0;
        end
        if (!in_range_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (beat_q == last_beat(word_q)) begin
          state_d = RESP;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and latched request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      word_q  <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      beat_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Output decode from registered state only (stall excepted); memory
  // strobes are confined to in-range ACCESS beats.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    stall      = req_valid & ~resp_valid;
    mem_re     = in_access_s & ~write_q & in_range_s;
    mem_we     = in_access_s & write_q & in_range_s;
    if (resp_valid) begin
      resp_rdata = acc_data_s;
      resp_err   = err_q;
    end else begin
      resp_rdata = 32'h0000_0000;
      resp_err   = 1'b0;
    end
    if (in_access_s) begin
      mem_addr = beat_sum_s[ADDR_W-1:0];
    end else begin
      mem_addr = '0;
    end
    if (mem_we) begin
      mem_wdata = wdata_q[{beat_q, 3'b000} +: 8];
    end else begin
      mem_wdata = 8'h00;
    end
  end

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
module tb_dmem_seq_ctrl;

  localparam int ADDR_W    = 4;
  localparam int MEM_DEPTH = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic              req_word;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  logic [7:0]        mem [0:15];
  logic              init_mem;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  int          n_re;
  int          n_we;
  logic [7:0]  last_wd;
  int          resp_seen;

  dmem_seq_ctrl #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_word   (req_word),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .stall      (stall),
    .mem_addr   (mem_addr),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory model: cell i powers up as 0xA0|i.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= {4'hA, 4'(i)};
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, wait (bounded) for its response, compare against the
  // scoreboard entry pushed at drive time.
  task automatic run_req(input string tag, input logic wr, input logic wd,
                         input logic [31:0] a, input logic [31:0] wdat,
                         input logic [31:0] exp_d, input logic exp_e,
                         input int exp_lat, input bit keep,
                         output int o_re, output int o_we, output logic [7:0] o_wd);
    exp_t e;
    int   cyc;
    int   bad;
    bit   got;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = a;
    req_wdata = wdat;
    e.d = exp_d; e.e = exp_e; e.lat = exp_lat;
    sb.push_back(e);
    #1;
    chk({tag, " ready_at_req"}, {31'b0, req_ready}, 32'd1);
    chk({tag, " stall_at_req"}, {31'b0, stall}, 32'd1);
    cyc = 0; bad = 0; got = 1'b0; o_re = 0; o_we = 0; o_wd = 8'h00;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (resp_valid === 1'b1) begin
        got = 1'b1;
      end else begin
        if (req_ready !== 1'b0 || stall !== 1'b1) bad++;
        if (mem_re === 1'b1) o_re++;
        if (mem_we === 1'b1) begin
          o_we++;
          o_wd = mem_wdata;
        end
      end
    end
    e = sb.pop_front();
    chk({tag, " resp_seen"}, {31'b0, got}, 32'd1);
    chk({tag, " latency"}, 32'(cyc), 32'(e.lat));
    chk({tag, " rdata"}, resp_rdata, e.d);
    chk({tag, " err"}, {31'b0, resp_err}, {31'b0, e.e});
    chk({tag, " busy_ready_stall"}, 32'(bad), 32'd0);
    chk({tag, " strobes_in_resp"}, {30'b0, mem_re, mem_we}, 32'd0);
    chk({tag, " stall_in_resp"}, {31'b0, stall}, 32'd0);
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    init_mem  = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_word  = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_mem = 1'b0;
    // Reset values
    chk("rst ready", {31'b0, req_ready}, 32'd1);
    chk("rst resp", {29'b0, resp_valid, resp_err, stall}, 32'd0);
    chk("rst rdata", resp_rdata, 32'd0);
    chk("rst mem", {20'b0, mem_addr, mem_re, mem_we, mem_wdata}, 32'd0);
    reset = 1'b0;

    // Reset in the middle of a word store at 0x4, after beat 1 is written
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
    req_addr = 32'h4; req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rstmid beat0", {24'b0, mem_we, mem_addr, mem_wdata[2:0]}, {24'b0, 1'b1, 4'h4, 3'h7});
    @(negedge clk);
    chk("rstmid beat1", {24'b0, mem_we, mem_addr, mem_wdata[2:0]}, {24'b0, 1'b1, 4'h5, 3'h6});
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid ready", {31'b0, req_ready}, 32'd1);
    chk("rstmid outs", {28'b0, resp_valid, resp_err, mem_re, mem_we}, 32'd0);
    chk("rstmid mem", {20'b0, mem_addr, mem_wdata}, 32'd0);
    chk("rstmid rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    resp_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid === 1'b1) resp_seen++;
    end
    chk("rstmid no_resp", 32'(resp_seen), 32'd0);
    chk("rstmid cells", {mem[4], mem[5], mem[6], mem[7]}, 32'hEFBE_A6A7);

    // Byte store then byte load at 0x2
    run_req("stb2", 1'b1, 1'b0, 32'h2, 32'h5555_55AB, 32'h0, 1'b0, 2, 1'b0, n_re, n_we, last_wd);
    chk("stb2 beats", {16'(n_re), 16'(n_we)}, {16'd0, 16'd1});
    chk("stb2 wdata", {24'b0, last_wd}, 32'hAB);
    run_req("ldb2", 1'b0, 1'b0, 32'h2, 32'h0, 32'h0000_00AB, 1'b0, 2, 1'b0, n_re, n_we, last_wd);
    chk("ldb2 beats", {16'(n_re), 16'(n_we)}, {16'd1, 16'd0});

    // Word store then word load at 0x8
    run_req("stw8", 1'b1, 1'b1, 32'h8, 32'h1234_5678, 32'h0, 1'b0, 5, 1'b0, n_re, n_we, last_wd);
    chk("stw8 beats", {16'(n_re), 16'(n_we)}, {16'd0, 16'd4});
    chk("stw8 cells", {mem[8], mem[9], mem[10], mem[11]}, 32'h7856_3412);
    run_req("ldw8", 1'b0, 1'b1, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 5, 1'b0, n_re, n_we, last_wd);
    chk("ldw8 beats", 32'(n_re), 32'd4);

    // Word load straddling the end of memory
    run_req("ldwC", 1'b0, 1'b1, 32'hC, 32'h0, 32'h0000_ADAC, 1'b1, 5, 1'b0, n_re, n_we, last_wd);
    chk("ldwC beats", 32'(n_re), 32'd2);

    // Byte loads at the last valid cell and the first invalid one
    run_req("ldbD", 1'b0, 1'b0, 32'hD, 32'h0, 32'h0000_00AD, 1'b0, 2, 1'b0, n_re, n_we, last_wd);
    run_req("ldbE", 1'b0, 1'b0, 32'hE, 32'h0, 32'h0, 1'b1, 2, 1'b0, n_re, n_we, last_wd);
    chk("ldbE beats", 32'(n_re), 32'd0);

    // Back-to-back with req_valid held: one IDLE bubble between requests
    run_req("b2b1", 1'b0, 1'b0, 32'h2, 32'h0, 32'h0000_00AB, 1'b0, 2, 1'b1, n_re, n_we, last_wd);
    run_req("b2b2", 1'b0, 1'b0, 32'h8, 32'h0, 32'h0000_0078, 1'b0, 2, 1'b0, n_re, n_we, last_wd);

`ifdef DMEM_ALIGN_CHK_EN
    run_req("ldw5", 1'b0, 1'b1, 32'h5, 32'h0, 32'h0, 1'b1, 1, 1'b0, n_re, n_we, last_wd);
    chk("ldw5 beats", 32'(n_re), 32'd0);
    run_req("ldwwrap", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 1, 1'b0, n_re, n_we, last_wd);
    chk("ldwwrap beats", 32'(n_re), 32'd0);
`else
    run_req("ldw5", 1'b0, 1'b1, 32'h5, 32'h0, 32'h78A7_A6BE, 1'b0, 5, 1'b0, n_re, n_we, last_wd);
    chk("ldw5 beats", 32'(n_re), 32'd4);
    run_req("ldwwrap", 1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, 32'h0, 1'b1, 5, 1'b0, n_re, n_we, last_wd);
    chk("ldwwrap beats", 32'(n_re), 32'd0);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
